// File: rtl/token_thinning_scheduler.sv
// token_thinning_scheduler: thins per-channel token streams by a programmable ratio and round-robins the credits onto one output
// Ports: clk, rst (async, active-high); a[N_CH] input tokens; cfg_we/cfg_ch/cfg_div set one channel's divide ratio;
// b/b_id registered output token and its owning channel; drop[N_CH] one-cycle pulse when a credit is lost to a full queue.
// Optional macro TOKEN_SCHED_PRIO0_EN: channel 0 gets strict priority over the round robin.
module token_thinning_scheduler #(
    parameter int N_CH = 4,
    parameter int DIV_W = 4,
    parameter int PEND_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    output logic                    b,
    output logic [$clog2(N_CH)-1:0] b_id,
    output logic [N_CH-1:0]         drop
);
    localparam int IW = $clog2(N_CH);
    logic [N_CH-1:0] wr, credit, grant, elig, drop_nxt;
    logic [IW-1:0] ptr, gid, j;
    logic any;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div, phase;
        logic [PEND_W-1:0] pend;
        // out-of-range cfg_ch decodes to no channel, so the write is ignored
        assign wr[i] = cfg_we && cfg_ch == IW'(i);
        assign credit[i] = a[i] && !wr[i] && phase == ((div == '0) ? '0 : div - 1'b1);
        assign grant[i] = any && gid == IW'(i);
        assign elig[i] = pend != '0;
        assign drop_nxt[i] = credit[i] && !grant[i] && pend == '1;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div <= DIV_W'(2);
                phase <= '0;
                pend <= '0;
            end else begin
                if (wr[i]) begin
                    div <= cfg_div;
                    phase <= '0;
                end else if (a[i]) phase <= credit[i] ? '0 : phase + 1'b1;
                if (credit[i] && !grant[i] && pend != '1) pend <= pend + 1'b1;
                else if (grant[i] && !credit[i]) pend <= pend - 1'b1;
            end
        end
    end
    // scan from ptr+N down to ptr+1 so the nearest eligible channel after ptr wins
    always_comb begin
        any = 1'b0;
        gid = ptr;
        j = ptr;
        for (int k = N_CH; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % N_CH);
            if (elig[j]) begin
                any = 1'b1;
                gid = j;
            end
        end
`ifdef TOKEN_SCHED_PRIO0_EN
        if (elig[0]) begin
            any = 1'b1;
            gid = '0;
        end
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b <= 1'b0;
            b_id <= '0;
            drop <= '0;
            ptr <= IW'(N_CH - 1);
        end else begin
            b <= any;
            drop <= drop_nxt;
            if (any) b_id <= gid;
`ifdef TOKEN_SCHED_PRIO0_EN
            if (any && !elig[0]) ptr <= gid;
`else
            if (any) ptr <= gid;
`endif
        end
    end
endmodule

// File: tb/tb_token_thinning_scheduler.sv
// tb_token_thinning_scheduler: table, directed and random checks of token_thinning_scheduler against a reference model
module tb_token_thinning_scheduler;
    localparam int N = 4;
    localparam int PMAX = 7;
    logic clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, b;
    logic [3:0] a = '0, cfg_div = '0, drop;
    logic [1:0] cfg_ch = '0, b_id;
    int n_cmp = 0, n_bad = 0;
    int m_div[N], m_cnt[N], m_pend[N], m_ptr, m_b, m_bid, m_drop;
    int n_b, n_drop, n_ch[N];
    typedef struct {
        logic [3:0] a;
        logic eb;
        logic [1:0] eid;
    } vec_t;
    vec_t tbl[18];
    logic [17:0] ap, bp;

    token_thinning_scheduler #(.N_CH(N), .DIV_W(4), .PEND_W(3)) dut (
        .clk(clk), .rst(rst), .a(a), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .b(b), .b_id(b_id), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        n_b = 0;
        n_drop = 0;
        for (int i = 0; i < N; i++) n_ch[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_div[i] = 2;
            m_cnt[i] = 0;
            m_pend[i] = 0;
        end
        m_ptr = N - 1;
        m_b = 0;
        m_bid = 0;
        m_drop = 0;
    endtask

    // one clock of the scheduler: count tokens toward the ratio, queue credits, serve one queue
    task automatic model_step();
        int g, p, cred;
        g = -1;
`ifdef TOKEN_SCHED_PRIO0_EN
        if (m_pend[0] > 0) g = 0;
`endif
        for (int k = 1; k <= N; k++) if (g < 0 && m_pend[(m_ptr + k) % N] > 0) g = (m_ptr + k) % N;
        m_drop = 0;
        for (int i = 0; i < N; i++) begin
            cred = 0;
            if (cfg_we && int'(cfg_ch) == i) begin
                m_div[i] = int'(cfg_div);
                m_cnt[i] = 0;
            end else if (a[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] >= (m_div[i] == 0 ? 1 : m_div[i])) begin
                    m_cnt[i] = 0;
                    cred = 1;
                end
            end
            p = m_pend[i] + cred - (g == i ? 1 : 0);
            if (p > PMAX) begin
                p = PMAX;
                m_drop |= 1 << i;
            end
            m_pend[i] = p;
        end
        m_b = g >= 0 ? 1 : 0;
        if (g >= 0) begin
            m_bid = g;
`ifdef TOKEN_SCHED_PRIO0_EN
            if (g > 0) m_ptr = g;
`else
            m_ptr = g;
`endif
        end
    endtask

    task automatic step(input logic [3:0] av);
        a = av;
        model_step();
        @(posedge clk);
        #1;
        check("b", int'(b), m_b);
        check("b_id", int'(b_id), m_bid);
        check("drop", int'(drop), m_drop);
        if (b) begin
            n_b++;
            n_ch[b_id]++;
        end
        n_drop += $countones(drop);
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [3:0] dv, input logic [3:0] av);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_div = dv;
        step(av);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a = '0;
        cfg_we = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
    endtask

    initial begin
        model_reset();
        clr();
        @(posedge clk);
        #1;
        check("rst_b", int'(b), 0);
        check("rst_b_id", int'(b_id), 0);
        check("rst_drop", int'(drop), 0);
        rst = 1'b0;

        // default halving on ch0: pattern followed by two idle cycles
        ap = 18'b110011101000111100;
        bp = 18'b001000100100001010;
        for (int i = 0; i < 18; i++) begin
            tbl[i].a = {3'b000, ap[17-i]};
            tbl[i].eb = bp[17-i];
            tbl[i].eid = 2'd0;
        end
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].a);
            check("t1_b", int'(b), int'(tbl[i].eb));
            check("t1_b_id", int'(b_id), int'(tbl[i].eid));
        end
        check("t1_count", n_b, 5);

        do_reset();
        cfg(2'd1, 4'd3, 4'b0000);
        for (int i = 0; i < 9; i++) step(4'b0010);
        for (int i = 0; i < 4; i++) step(4'b0000);
        check("t2_count", n_b, 3);
        check("t2_ch1", n_ch[1], 3);

        do_reset();
        for (int i = 0; i < 16; i++) step(4'b1111);
        for (int i = 0; i < 20; i++) step(4'b0000);
        check("t3_count", n_b, 32);
        for (int i = 0; i < N; i++) check("t3_per_ch", n_ch[i], 8);
        check("t3_drops", n_drop, 0);

        do_reset();
        for (int i = 0; i < N; i++) cfg(2'(i), 4'd1, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step(4'b1111);
            if (i >= 15) begin
                check("t4_drop_cnt", $countones(drop), 3);
                check("t4_b", int'(b), 1);
            end
        end
        for (int i = 0; i < 30; i++) step(4'b0000);

        do_reset();
        step(4'b0100);
        cfg(2'd2, 4'd4, 4'b0100);
        for (int i = 0; i < 3; i++) step(4'b0100);
        for (int i = 0; i < 3; i++) step(4'b0000);
        check("t5_none", n_b, 0);
        step(4'b0100);
        for (int i = 0; i < 3; i++) step(4'b0000);
        check("t5_one", n_b, 1);
        check("t5_ch2", n_ch[2], 1);

        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1111);
        check("t6_pre_b", int'(b), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_b", int'(b), 0);
        check("t6_async_drop", int'(drop), 0);
        check("t6_async_b_id", int'(b_id), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        for (int i = 0; i < 6; i++) step(4'b0000);
        check("t6_quiet", n_b, 0);

`ifdef TOKEN_SCHED_PRIO0_EN
        do_reset();
        cfg(2'd0, 4'd1, 4'b0000);
        cfg(2'd1, 4'd1, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step(4'b0011);
            if (i >= 1) check("t7_prio_id", int'(b_id), 0);
        end
        check("t7_ch1_drops", n_drop > 0 ? 1 : 0, 1);
        for (int i = 0; i < 12; i++) step(4'b0000);
`endif

        do_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = 2'($urandom);
                cfg_div = 4'($urandom_range(0, 4));
            end
            step(4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
